sprite_blitter: RTL and testbench

- Drawing responder for the game controller's draw handshake: when a draw request is raised, copies one SPR_W x SPR_H sprite from sprite ROM into the VGA adapter's pixel-write port at a given origin.
- Pulses `finished` once for each completed sprite.
- Instantiated once in the datapath and shared by the stage, tile, explosion, bomb, player and HP draw states.
- Supports transparency keying, horizontal mirroring and screen-edge clipping.

---
 rtl/bomberman_pkg.sv | 40 ++++
 rtl/sprite_pixel_counter.sv | 56 +++++
 rtl/sprite_blitter.sv | 160 ++++++++++++++++
 tb/tb_sprite_blitter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/bomberman_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bomberman_pkg
// Description : Shared sprite/screen dimensions, colour key, blitter state
//               encoding and sprite-ID constants for the game datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package bomberman_pkg;

    localparam int C_SPR_W    = 8;
    localparam int C_SPR_H    = 8;
    localparam int C_ID_W     = 4;
    localparam int C_X_W      = 8;
    localparam int C_Y_W      = 7;
    localparam int C_SCREEN_W = 160;
    localparam int C_SCREEN_H = 120;
    localparam int C_COLOUR_W = 3;

    localparam logic [C_COLOUR_W-1:0] C_TRANSPARENT = 3'b101;

    localparam int               C_BLT_STATE_W = 2;
    localparam logic [C_BLT_STATE_W-1:0] C_BLT_IDLE  = 2'd0;
    localparam logic [C_BLT_STATE_W-1:0] C_BLT_FETCH = 2'd1;
    localparam logic [C_BLT_STATE_W-1:0] C_BLT_DONE  = 2'd2;

    typedef enum logic [C_BLT_STATE_W-1:0] {
        BLT_IDLE  = C_BLT_IDLE,
        BLT_FETCH = C_BLT_FETCH,
        BLT_DONE  = C_BLT_DONE
    } blt_state_t;

    localparam logic [C_ID_W-1:0] C_SPR_TILE      = 4'd0;
    localparam logic [C_ID_W-1:0] C_SPR_EXPLOSION = 4'd1;
    localparam logic [C_ID_W-1:0] C_SPR_BOMB      = 4'd2;
    localparam logic [C_ID_W-1:0] C_SPR_P1        = 4'd3;
    localparam logic [C_ID_W-1:0] C_SPR_P2        = 4'd4;
    localparam logic [C_ID_W-1:0] C_SPR_HEART     = 4'd5;

endpackage
`default_nettype wire

// File: rtl/sprite_pixel_counter.sv
`default_nettype none
// ============================================================================
// Module      : sprite_pixel_counter
// Description : Raster col/row counter over one sprite with clear, enable,
//               column wrap into row, and a last-pixel flag.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_pixel_counter
    import bomberman_pkg::*;
#(
    parameter int SPR_W = C_SPR_W,
    parameter int SPR_H = C_SPR_H
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       i_clear,
    input  logic                       i_enable,
    output logic [$clog2(SPR_W)-1:0]   o_col,
    output logic [$clog2(SPR_H)-1:0]   o_row,
    output logic                       o_last
);

    localparam int C_CW = $clog2(SPR_W);
    localparam int C_RW = $clog2(SPR_H);
    localparam logic [C_CW-1:0] C_COL_MAX = C_CW'(SPR_W - 1);
    localparam logic [C_RW-1:0] C_ROW_MAX = C_RW'(SPR_H - 1);

    logic [C_CW-1:0] r_col;
    logic [C_RW-1:0] r_row;
    logic            w_col_wrap;
    logic            w_row_wrap;

    assign w_col_wrap = (r_col == C_COL_MAX);
    assign w_row_wrap = (r_row == C_ROW_MAX);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_clear) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_enable) begin
            r_col <= w_col_wrap ? '0 : r_col + 1'b1;
            if (w_col_wrap) begin
                r_row <= w_row_wrap ? '0 : r_row + 1'b1;
            end
        end
    end

    assign o_col  = r_col;
    assign o_row  = r_row;
    assign o_last = w_col_wrap & w_row_wrap;

endmodule
`default_nettype wire

// File: rtl/sprite_blitter.sv
`default_nettype none
// ============================================================================
// Module      : sprite_blitter
// Description : Copies one sprite from synchronous ROM to the VGA pixel port
//               with colour keying, horizontal mirroring and edge clipping.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_blitter
    import bomberman_pkg::*;
#(
    parameter int SPR_W    = C_SPR_W,
    parameter int SPR_H    = C_SPR_H,
    parameter int ID_W     = C_ID_W,
    parameter int X_W      = C_X_W,
    parameter int Y_W      = C_Y_W,
    parameter int SCREEN_W = C_SCREEN_W,
    parameter int SCREEN_H = C_SCREEN_H,
    parameter int COLOUR_W = C_COLOUR_W,
    parameter logic [COLOUR_W-1:0] TRANSPARENT = C_TRANSPARENT
) (
    input  logic                                   clock,
    input  logic                                   resetn,
    input  logic                                   start,
    input  logic [X_W-1:0]                         x_origin,
    input  logic [Y_W-1:0]                         y_origin,
    input  logic [ID_W-1:0]                        sprite_id,
    input  logic                                   hflip,
    input  logic                                   transparent_en,
    output logic [ID_W+$clog2(SPR_W*SPR_H)-1:0]    rom_addr,
    input  logic [COLOUR_W-1:0]                    rom_data,
    output logic [X_W-1:0]                         vga_x,
    output logic [Y_W-1:0]                         vga_y,
    output logic [COLOUR_W-1:0]                    vga_colour,
    output logic                                   vga_plot,
    output logic                                   busy,
    output logic                                   finished
);

    localparam int C_CW = $clog2(SPR_W);
    localparam int C_RW = $clog2(SPR_H);
    localparam logic [X_W:0] C_X_LIM = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] C_Y_LIM = (Y_W+1)'(SCREEN_H);

    blt_state_t      r_state;
    blt_state_t      w_next_state;
    logic            w_accept;
    logic            w_cnt_en;
    logic            w_last;
    logic [C_CW-1:0] w_col;
    logic [C_CW-1:0] w_rom_col;
    logic [C_RW-1:0] w_row;

    logic [X_W-1:0]  r_x_org;
    logic [Y_W-1:0]  r_y_org;
    logic [ID_W-1:0] r_id;
    logic            r_hflip;
    logic            r_key_en;

    logic [X_W:0]    w_sx;
    logic [Y_W:0]    w_sy;
    logic [X_W:0]    r_px;
    logic [Y_W:0]    r_py;
    logic            r_pipe_valid;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= BLT_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_cnt_en     = 1'b0;
        busy         = 1'b0;
        finished     = 1'b0;
        case (r_state)
            BLT_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = BLT_FETCH;
                end
            end
            BLT_FETCH: begin
                busy     = 1'b1;
                w_cnt_en = 1'b1;
                if (w_last) begin
                    w_next_state = BLT_DONE;
                end
            end
            BLT_DONE: begin
                busy         = 1'b1;
                finished     = 1'b1;
                w_next_state = BLT_IDLE;
            end
            default: w_next_state = BLT_IDLE;
        endcase
    end

    sprite_pixel_counter #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H)
    ) u_counter (
        .clock    (clock),
        .resetn   (resetn),
        .i_clear  (w_accept),
        .i_enable (w_cnt_en),
        .o_col    (w_col),
        .o_row    (w_row),
        .o_last   (w_last)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_x_org  <= '0;
            r_y_org  <= '0;
            r_id     <= '0;
            r_hflip  <= 1'b0;
            r_key_en <= 1'b0;
        end else if (w_accept) begin
            r_x_org  <= x_origin;
            r_y_org  <= y_origin;
            r_id     <= sprite_id;
            r_hflip  <= hflip;
            r_key_en <= transparent_en;
        end
    end

    // SPR_W is a power of two, so SPR_W-1-col is simply the bitwise inverse.
    assign w_rom_col = r_hflip ? ~w_col : w_col;
    assign rom_addr  = {r_id, w_row, w_rom_col};

    // One extra bit keeps right/bottom overflow visible to the clip test.
    assign w_sx = {1'b0, r_x_org} + (X_W+1)'(w_col);
    assign w_sy = {1'b0, r_y_org} + (Y_W+1)'(w_row);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_px         <= '0;
            r_py         <= '0;
            r_pipe_valid <= 1'b0;
        end else begin
            r_px         <= w_sx;
            r_py         <= w_sy;
            r_pipe_valid <= (r_state == BLT_FETCH);
        end
    end

    assign vga_x      = r_px[X_W-1:0];
    assign vga_y      = r_py[Y_W-1:0];
    assign vga_colour = rom_data;
    assign vga_plot   = r_pipe_valid
                      & ~(r_key_en & (rom_data == TRANSPARENT))
                      & (r_px < C_X_LIM)
                      & (r_py < C_Y_LIM);

endmodule
`default_nettype wire

// File: tb/tb_sprite_blitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_blitter
// Description : Self-checking bench for sprite_blitter with a ROM model and a
//               queue of expected plots derived from the request parameters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_blitter;

    logic        clock = 1'b0;
    logic        resetn;
    logic        start;
    logic [7:0]  x_origin;
    logic [6:0]  y_origin;
    logic [3:0]  sprite_id;
    logic        hflip;
    logic        transparent_en;
    logic [9:0]  rom_addr;
    logic [2:0]  rom_data;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        busy;
    logic        finished;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int          cyc;
        logic [17:0] pix;
    } exp_t;

    exp_t       sb[$];
    logic [2:0] rom [0:1023];

    sprite_blitter u_dut (
        .clock          (clock),
        .resetn         (resetn),
        .start          (start),
        .x_origin       (x_origin),
        .y_origin       (y_origin),
        .sprite_id      (sprite_id),
        .hflip          (hflip),
        .transparent_en (transparent_en),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .vga_x          (vga_x),
        .vga_y          (vga_y),
        .vga_colour     (vga_colour),
        .vga_plot       (vga_plot),
        .busy           (busy),
        .finished       (finished)
    );

    always #5 clock = ~clock;

    always @(posedge clock) rom_data <= rom[rom_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int ox, input int oy, input int id, input bit hf, input bit tk);
        x_origin       = 8'(ox);
        y_origin       = 7'(oy);
        sprite_id      = 4'(id);
        hflip          = hf;
        transparent_en = tk;
        start          = 1'b1;
    endtask

    task automatic build_expected(input int ox, input int oy, input int id, input bit hf, input bit tk);
        for (int k = 0; k < 64; k++) begin
            int         r, c, rc, x, y;
            logic [9:0] a;
            logic [2:0] col;
            r   = k / 8;
            c   = k % 8;
            rc  = hf ? 7 - c : c;
            a   = {4'(id), 3'(r), 3'(rc)};
            col = rom[a];
            x   = ox + c;
            y   = oy + r;
            if (x < 160 && y < 120 && !(tk && col == 3'b101))
                sb.push_back('{1 + k, {8'(x), 7'(y), col}});
        end
    endtask

    // Caller has already presented the request at a falling edge.
    task automatic draw(input int ox, input int oy, input int id, input bit hf, input bit tk,
                        input int gap, input bit hold, input bit toggle,
                        input int exp_plots, input string name);
        int   plots;
        bit   exp_plot;
        exp_t e;
        plots = 0;
        check({name, ":sb_empty_pre"}, sb.size(), 0);
        sb.delete();
        build_expected(ox, oy, id, hf, tk);
        repeat (gap) begin
            @(posedge clock);
            @(negedge clock);
            check({name, ":idle_gap_busy"}, busy, 0);
        end
        @(posedge clock);
        for (int n = 0; n <= 64; n++) begin
            @(negedge clock);
            if (n == 1) begin
                x_origin       = ~x_origin;
                y_origin       = ~y_origin;
                sprite_id      = ~sprite_id;
                hflip          = ~hflip;
                transparent_en = ~transparent_en;
            end
            if (toggle && n == 20) start = 1'b0;
            if (n < 64)
                check({name, ":rom_addr"}, rom_addr,
                      {22'd0, 4'(id), 3'(n / 8), 3'(hf ? 7 - (n % 8) : n % 8)});
            exp_plot = (sb.size() > 0) && (sb[0].cyc == n);
            check({name, ":plot_en"}, vga_plot, exp_plot);
            if (exp_plot) begin
                e = sb.pop_front();
                plots++;
                check({name, ":pixel"}, {vga_x, vga_y, vga_colour}, e.pix);
            end
            check({name, ":finished"}, finished, (n == 64));
            check({name, ":busy"}, busy, 1);
            if (n == 64 && !hold) start = 1'b0;
        end
        check({name, ":sb_drained"}, sb.size(), 0);
        check({name, ":plot_count"}, plots, exp_plots);
        if (!hold) begin
            @(negedge clock);
            check({name, ":idle_busy"}, busy, 0);
            check({name, ":idle_finished"}, finished, 0);
            check({name, ":idle_plot"}, vga_plot, 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int a = 0; a < 1024; a++) begin
            int id, k, r, c;
            id = a / 64;
            k  = a % 64;
            r  = k / 8;
            c  = k % 8;
            case (id)
                2:       rom[a] = 3'((r * 3 + c) % 8);
                3:       rom[a] = 3'(c);
                5:       rom[a] = (k % 6 == 0 && k < 60) ? 3'b101 : ((k % 2 == 1) ? 3'd3 : 3'd6);
                default: rom[a] = 3'((k * 5 + id) % 8);
            endcase
        end

        resetn = 1'b0;
        set_req(0, 0, 0, 1'b0, 1'b0);
        start = 1'b0;
        repeat (3) @(negedge clock);
        check("reset:plot", vga_plot, 0);
        check("reset:busy", busy, 0);
        check("reset:finished", finished, 0);
        check("reset:rom_addr", rom_addr, 0);
        check("reset:vga_x", vga_x, 0);
        check("reset:vga_y", vga_y, 0);
        resetn = 1'b1;
        @(negedge clock);
        check("idle:busy", busy, 0);

        set_req(16, 24, 2, 1'b0, 1'b0);
        draw(16, 24, 2, 1'b0, 1'b0, 0, 1'b0, 1'b0, 64, "basic");

        set_req(50, 60, 5, 1'b0, 1'b1);
        draw(50, 60, 5, 1'b0, 1'b1, 0, 1'b0, 1'b0, 54, "key_on");
        set_req(50, 60, 5, 1'b0, 1'b0);
        draw(50, 60, 5, 1'b0, 1'b0, 0, 1'b0, 1'b0, 64, "key_off");

        set_req(100, 10, 3, 1'b1, 1'b0);
        draw(100, 10, 3, 1'b1, 1'b0, 0, 1'b0, 1'b0, 64, "mirror");

        set_req(156, 116, 2, 1'b0, 1'b0);
        draw(156, 116, 2, 1'b0, 1'b0, 0, 1'b0, 1'b0, 16, "clip");

        set_req(40, 50, 0, 1'b0, 1'b0);
        draw(40, 50, 0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 64, "hs_a");
        set_req(48, 50, 1, 1'b0, 1'b0);
        draw(48, 50, 1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 64, "hs_b");

        set_req(0, 0, 4, 1'b0, 1'b0);
        draw(0, 0, 4, 1'b0, 1'b0, 0, 1'b0, 1'b1, 64, "toggle");

        set_req(30, 40, 2, 1'b0, 1'b0);
        @(posedge clock);
        for (int n = 0; n <= 31; n++) @(negedge clock);
        check("rst_mid:plot_before", vga_plot, 1);
        check("rst_mid:busy_before", busy, 1);
        #2;
        resetn = 1'b0;
        start  = 1'b0;
        #1;
        check("rst_mid:plot", vga_plot, 0);
        check("rst_mid:busy", busy, 0);
        check("rst_mid:finished", finished, 0);
        check("rst_mid:rom_addr", rom_addr, 0);
        repeat (3) begin
            @(negedge clock);
            check("rst_hold:finished", finished, 0);
            check("rst_hold:busy", busy, 0);
        end
        resetn = 1'b1;
        check("rst_rel:vga_x", vga_x, 0);
        check("rst_rel:vga_y", vga_y, 0);
        @(negedge clock);
        check("rst_rel:finished", finished, 0);
        check("rst_rel:busy", busy, 0);

        set_req(8, 8, 2, 1'b1, 1'b0);
        draw(8, 8, 2, 1'b1, 1'b0, 0, 1'b0, 1'b0, 64, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
